// File: rtl/cpu_pkg.sv
// Shared CPU types: the SIC instruction packet and dispatch FSM states.
// Imported by the dispatch unit and its buffer.
package cpu_pkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  issue_id;
        logic [5:0]  opcode;
        logic [31:0] operand;
    } sic_packet_t;

    typedef logic [0:0] dispatch_state_t;

    localparam dispatch_state_t D_IDLE  = 1'b0;
    localparam dispatch_state_t D_OFFER = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head is the oldest entry.
// Ports: clk, rst, flush, push/push_data, pop, head, count.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem_q [DEPTH];
    T               mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sic_dispatch_unit.sv
// Buffers issued packets and hands each, in order, to one idle SIC (round-robin).
// Ports: in_* issue side, flush, sic_req_instr/sic_packet per SIC, dispatch_* report, fifo_count.
module sic_dispatch_unit
    import cpu_pkg::*;
#(
    parameter int NUM_SICS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  sic_packet_t                   in_packet,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic [NUM_SICS-1:0]           sic_req_instr,
    output sic_packet_t [NUM_SICS-1:0]    sic_packet,
    output logic                          dispatch_fire,
    output logic [$clog2(NUM_SICS)-1:0]   dispatch_sic,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SW = $clog2(NUM_SICS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dispatch_state_t state_q, state_d;
    logic [SW-1:0]   target_q, target_d;
    logic [SW-1:0]   last_grant_q, last_grant_d;
    logic [SW-1:0]   dispatch_sic_q, dispatch_sic_d;
    logic            dispatch_fire_q, dispatch_fire_d;
    sic_packet_t     head;
    logic [CW-1:0]   count;
    logic            push, pop;

    // First requester strictly after 'last', wrapping around.
    function automatic logic [SW-1:0] rr_pick(
        input logic [NUM_SICS-1:0] req,
        input logic [SW-1:0]       last
    );
        logic [SW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SICS; k++) begin
            idx = (int'(last) + k) % NUM_SICS;
            if (!found && req[idx]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A pop never frees a slot for the same cycle's push.
    assign in_ready = (count < CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .T     (sic_packet_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (in_packet),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        last_grant_d    = last_grant_q;
        dispatch_sic_d  = dispatch_sic_q;
        dispatch_fire_d = 1'b0;
        pop             = 1'b0;
        case (state_q)
            D_IDLE: begin
                if ((count != '0) && (|sic_req_instr)) begin
                    target_d = rr_pick(sic_req_instr, last_grant_q);
                    state_d  = D_OFFER;
                end
            end
            D_OFFER: begin
                // Target drops req once it has taken the packet.
                if (!sic_req_instr[target_q]) begin
                    pop             = 1'b1;
                    last_grant_d    = target_q;
                    dispatch_fire_d = 1'b1;
                    dispatch_sic_d  = target_q;
                    state_d         = D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase
        // A completing hand-off still reports; the SIC already has it.
        if (flush) begin
            state_d = D_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= D_IDLE;
            target_q        <= '0;
            last_grant_q    <= SW'(NUM_SICS - 1);
            dispatch_sic_q  <= '0;
            dispatch_fire_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            last_grant_q    <= last_grant_d;
            dispatch_sic_q  <= dispatch_sic_d;
            dispatch_fire_q <= dispatch_fire_d;
        end
    end

    always_comb begin
        sic_packet = '0;
        if (state_q == D_OFFER) begin
            sic_packet[target_q]       = head;
            sic_packet[target_q].valid = 1'b1;
        end
    end

    assign dispatch_fire = dispatch_fire_q;
    assign dispatch_sic  = dispatch_sic_q;
    assign fifo_count    = count;

endmodule

// File: tb/tb_sic_dispatch_unit.sv
// Bench for sic_dispatch_unit: modelled SICs plus an in-order hand-off scoreboard.
// Ports: drives every DUT port; prints one summary line.
module tb_sic_dispatch_unit;
    import cpu_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    sic_packet_t       in_packet;
    logic              in_ready;
    logic              flush;
    logic [3:0]        sic_req_instr;
    sic_packet_t [3:0] sic_packet;
    logic              dispatch_fire;
    logic [1:0]        dispatch_sic;
    logic [2:0]        fifo_count;

    sic_dispatch_unit #(
        .NUM_SICS   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_packet     (in_packet),
        .in_ready      (in_ready),
        .flush         (flush),
        .sic_req_instr (sic_req_instr),
        .sic_packet    (sic_packet),
        .dispatch_fire (dispatch_fire),
        .dispatch_sic  (dispatch_sic),
        .fifo_count    (fifo_count)
    );

    typedef struct {
        logic [7:0] id;
        int         sic;
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    logic       mon_en;
    logic       pend;
    int         pend_sic;
    logic [3:0] want;
    int         hold [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SIC model: requests while idle, drops req on a visible offer once
    // its pre-wait count has run out.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sic_req_instr[i] = want[i] && !(sic_packet[i].valid && hold[i] == 0);
        end
    end

    // SIC state update and hand-off scoreboard.
    always begin
        @(negedge clk);
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (dispatch_fire === 1'b1 && dispatch_sic === 2'(i)) want[i] = 1'b0;
                if (sic_packet[i].valid === 1'b1 && hold[i] > 0) hold[i] = hold[i] - 1;
            end
            #1;
            checks++;
            if (pend) begin
                if (dispatch_fire !== 1'b1 || dispatch_sic !== 2'(pend_sic)) begin
                    errors++;
                    $display("FAIL fire_report got fire=%b sic=%0d exp fire=1 sic=%0d",
                             dispatch_fire, dispatch_sic, pend_sic);
                end
                pend = 1'b0;
            end else if (dispatch_fire !== 1'b0) begin
                errors++;
                $display("FAIL spurious_fire got fire=%b exp 0", dispatch_fire);
            end
            checks++;
            if ($countones({sic_packet[3].valid, sic_packet[2].valid,
                            sic_packet[1].valid, sic_packet[0].valid}) > 1) begin
                errors++;
                $display("FAIL one_offer got several valid offers");
            end
            for (int i = 0; i < 4; i++) begin
                if (sic_packet[i].valid === 1'b1 && sic_req_instr[i] === 1'b0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL handoff got id=%0d to sic%0d exp none",
                                 sic_packet[i].issue_id, i);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (sic_packet[i].issue_id !== e.id || i != e.sic) begin
                            errors++;
                            $display("FAIL handoff got id=%0d sic=%0d exp id=%0d sic=%0d",
                                     sic_packet[i].issue_id, i, e.id, e.sic);
                        end
                    end
                    pend     = 1'b1;
                    pend_sic = i;
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        want     = '0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        pend   = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic push_pkt(input logic [7:0] id, input int sic);
        exp_t e;
        in_valid           = 1'b1;
        in_packet          = '0;
        in_packet.valid    = 1'b1;
        in_packet.issue_id = id;
        in_packet.operand  = {24'h0, id};
        e.id  = id;
        e.sic = sic;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 60) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending exp 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("FAIL rst_count got %0d exp 0", fifo_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if (dispatch_fire !== 1'b0 || dispatch_sic !== 2'd0) begin
            errors++;
            $display("FAIL rst_dispatch got fire=%b sic=%0d exp 0 0", dispatch_fire, dispatch_sic);
        end
        checks++;
        if (sic_packet !== '0) begin
            errors++; $display("FAIL rst_offers got %h exp 0", sic_packet);
        end
    endtask

    task automatic test_single();
        do_reset();
        want = 4'b1111;
        push_pkt(8'd5, 0);
        @(posedge clk); #1;
        @(negedge clk); #2;
        checks++;
        if (sic_packet[0].valid !== 1'b1 || sic_packet[0].issue_id !== 8'd5) begin
            errors++;
            $display("FAIL single_offer got v=%b id=%0d exp v=1 id=5",
                     sic_packet[0].valid, sic_packet[0].issue_id);
        end
        @(posedge clk); #1;
        @(negedge clk); #2;
        checks++;
        if (dispatch_fire !== 1'b1 || dispatch_sic !== 2'd0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_fire got fire=%b sic=%0d cnt=%0d exp 1 0 0",
                     dispatch_fire, dispatch_sic, fifo_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 1; k <= 4; k++) push_pkt(8'(k), k - 1);
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_full got cnt=%0d rdy=%b exp 4 0", fifo_count, in_ready);
        end
        @(posedge clk); #1;
        in_valid           = 1'b1;
        in_packet          = '0;
        in_packet.issue_id = 8'd99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++; $display("FAIL rr_no_push got cnt=%0d exp 4", fifo_count);
        end
        @(posedge clk); #1;
        want = 4'b1111;
        drain("rr");
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("FAIL rr_empty got cnt=%0d exp 0", fifo_count);
        end
    endtask

    task automatic test_hold_offer();
        int fires;
        int offers;
        fires  = 0;
        offers = 0;
        do_reset();
        want    = 4'b0100;
        hold[2] = 3;
        push_pkt(8'd7, 2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #2;
            if (dispatch_fire === 1'b1) fires++;
            if (sic_packet[2].valid === 1'b1) begin
                offers++;
                checks++;
                if (sic_packet[2].issue_id !== 8'd7 || sic_packet[0].valid !== 1'b0 ||
                    sic_packet[1].valid !== 1'b0 || sic_packet[3].valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_offer got id=%0d exp id=7 on sic2 only",
                             sic_packet[2].issue_id);
                end
            end
        end
        checks++;
        if (fires != 1 || offers != 3 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL hold_summary got fires=%0d offers=%0d cnt=%0d exp 1 3 0",
                     fires, offers, fifo_count);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 0; k < 4; k++) push_pkt(8'(30 + k), 0);
        want = 4'b0001;
        @(posedge clk); #1;
        in_valid           = 1'b1;
        in_packet          = '0;
        in_packet.issue_id = 8'd50;
        @(negedge clk); #2;
        checks++;
        if (in_ready !== 1'b0 || sic_packet[0].valid !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_pre got rdy=%b v0=%b exp 0 1", in_ready, sic_packet[0].valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_post got cnt=%0d rdy=%b exp 3 1", fifo_count, in_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        want    = 4'b0010;
        hold[1] = 5;
        push_pkt(8'd10, 1);
        push_pkt(8'd11, 1);
        flush = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (sic_packet[1].valid !== 1'b1 || sic_req_instr[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got v1=%b req1=%b exp 1 1", sic_packet[1].valid, sic_req_instr[1]);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd0 || sic_packet !== '0 || dispatch_fire !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold got cnt=%0d offers=%h fire=%b exp 0 0 0",
                     fifo_count, sic_packet, dispatch_fire);
        end
        @(posedge clk); #1;
        hold[1] = 0;
        push_pkt(8'd12, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (dispatch_fire !== 1'b1 || dispatch_sic !== 2'd1 || fifo_count !== 3'd0 ||
            sic_packet !== '0) begin
            errors++;
            $display("FAIL flush_ack got fire=%b sic=%0d cnt=%0d exp 1 1 0",
                     dispatch_fire, dispatch_sic, fifo_count);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        want = 4'b1000;
        push_pkt(8'd19, 3);
        repeat (3) @(posedge clk);
        #1;
        want[3] = 1'b1;
        hold[3] = 9;
        push_pkt(8'd20, 3);
        @(posedge clk); #1;
        @(negedge clk); #2;
        checks++;
        if (sic_packet[3].valid !== 1'b1 || dispatch_sic !== 2'd3) begin
            errors++;
            $display("FAIL rmo_pre got v3=%b sic=%0d exp 1 3", sic_packet[3].valid, dispatch_sic);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk); #2;
        checks++;
        if (fifo_count !== 3'd0 || in_ready !== 1'b1 || dispatch_fire !== 1'b0 ||
            dispatch_sic !== 2'd0 || sic_packet !== '0) begin
            errors++;
            $display("FAIL rmo_reset got cnt=%0d rdy=%b fire=%b sic=%0d offers=%h exp 0 1 0 0 0",
                     fifo_count, in_ready, dispatch_fire, dispatch_sic, sic_packet);
        end
        @(posedge clk); #1;
        want = 4'b1111;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        push_pkt(8'd21, 0);
        drain("rmo");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        pend      = 1'b0;
        pend_sic  = 0;
        want      = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        flush     = 1'b0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_offer();
        test_full_push_pop();
        test_flush();
        test_reset_mid_offer();
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
